// File: rtl/npu_cmd_master_if.sv
// npu_cmd_master_if: command/response and register-bus signals of the NPU command master.
interface npu_cmd_master_if #(
    parameter int TIMEOUT_W = 16
);
    logic                 CMD_VALID;
    logic                 CMD_READY;
    logic [1:0]           CMD_TYPE;
    logic [7:0]           CMD_ADR;
    logic [31:0]          CMD_WDATA;
    logic                 RSP_VALID;
    logic [31:0]          RSP_DATA;
    logic                 RSP_ERR;
    logic                 BUSY;
    logic [TIMEOUT_W-1:0] TIMEOUT;
    logic [7:0]           ADR;
    logic                 WR;
    logic                 RD;
    logic [31:0]          WDATA;
    logic [31:0]          RDATA;
    logic                 INT;

    modport master (
        input  CMD_VALID, CMD_TYPE, CMD_ADR, CMD_WDATA, TIMEOUT, RDATA, INT,
        output CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR, BUSY, ADR, WR, RD, WDATA
    );

    modport slave (
        output CMD_VALID, CMD_TYPE, CMD_ADR, CMD_WDATA, TIMEOUT, RDATA, INT,
        input  CMD_READY, RSP_VALID, RSP_DATA, RSP_ERR, BUSY, ADR, WR, RD, WDATA
    );
endinterface

// File: rtl/npu_cmd_master.sv
// npu_cmd_master: queued WRITE/READ/WAIT_INT command initiator for the NPU register bus.
// Define NPU_CMD_TIMEOUT_EN to bound WAIT_INT by the TIMEOUT port.
module npu_cmd_master #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT_W  = 16
) (
    input logic CLK,
    input logic RESET_X,
    npu_cmd_master_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, WAIT_INT} state_t;

    state_t        st;
    logic [41:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          push, pop, is_rd, int_seen;
    logic [1:0]    h_type;
    logic [7:0]    h_adr;
    logic [31:0]   h_wdata;
`ifdef NPU_CMD_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tcnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^bus.TIMEOUT;
`endif

    assign bus.CMD_READY = cnt != FIFO_DEPTH[AW:0];
    assign bus.BUSY = st != IDLE || cnt != '0;
    assign push = bus.CMD_VALID && bus.CMD_READY;
    assign pop = st == IDLE && cnt != '0;
    assign {h_type, h_adr, h_wdata} = mem[rp];

    always_ff @(posedge CLK)
        if (push) mem[wp] <= {bus.CMD_TYPE, bus.CMD_ADR, bus.CMD_WDATA};

    always_ff @(posedge CLK or negedge RESET_X)
        if (!RESET_X) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end

    always_ff @(posedge CLK or negedge RESET_X)
        if (!RESET_X) begin
            st            <= IDLE;
            is_rd         <= 1'b0;
            int_seen      <= 1'b0;
            bus.ADR       <= '0;
            bus.WDATA     <= '0;
            bus.WR        <= 1'b0;
            bus.RD        <= 1'b0;
            bus.RSP_VALID <= 1'b0;
            bus.RSP_DATA  <= '0;
            bus.RSP_ERR   <= 1'b0;
`ifdef NPU_CMD_TIMEOUT_EN
            tcnt          <= '0;
`endif
        end else begin
            bus.WR        <= 1'b0;
            bus.RD        <= 1'b0;
            bus.RSP_VALID <= 1'b0;
            // later clears below take priority over this set
            if (bus.INT) int_seen <= 1'b1;
            case (st)
                IDLE: if (pop) begin
                    if (h_type == 2'd0) begin
                        bus.ADR   <= h_adr;
                        bus.WDATA <= h_wdata;
                        bus.WR    <= 1'b1;
                        is_rd     <= 1'b0;
                        st        <= ISSUE;
                        if (h_adr == 8'h00 && h_wdata[0]) int_seen <= 1'b0;
                    end else if (h_type == 2'd1) begin
                        bus.ADR <= h_adr;
                        bus.RD  <= 1'b1;
                        is_rd   <= 1'b1;
                        st      <= ISSUE;
                    end else if (h_type == 2'd2) begin
                        st <= WAIT_INT;
`ifdef NPU_CMD_TIMEOUT_EN
                        tcnt <= '0;
`endif
                    end else begin
                        bus.RSP_VALID <= 1'b1;
                        bus.RSP_ERR   <= 1'b1;
                        bus.RSP_DATA  <= '0;
                    end
                end
                ISSUE: st <= is_rd ? RD_WAIT : IDLE;
                RD_WAIT: begin
                    bus.RSP_DATA  <= bus.RDATA;
                    bus.RSP_VALID <= 1'b1;
                    bus.RSP_ERR   <= 1'b0;
                    st            <= IDLE;
                end
                WAIT_INT: if (int_seen || bus.INT) begin
                    bus.RSP_VALID <= 1'b1;
                    bus.RSP_ERR   <= 1'b0;
                    bus.RSP_DATA  <= '0;
                    int_seen      <= 1'b0;
                    st            <= IDLE;
                end
`ifdef NPU_CMD_TIMEOUT_EN
                else if (bus.TIMEOUT != '0) begin
                    tcnt <= tcnt + 1'b1;
                    if (tcnt == bus.TIMEOUT - 1'b1) begin
                        bus.RSP_VALID <= 1'b1;
                        bus.RSP_ERR   <= 1'b1;
                        bus.RSP_DATA  <= '0;
                        st            <= IDLE;
                    end
                end
`endif
                default: st <= IDLE;
            endcase
        end
endmodule
